// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : MEM pipeline stage of the 5-stage MIPS core (between EXE and WB).
//
// Holds the EXE->MEM pipeline register, issues at most one load/store at a
// time on the SRAM-like data bus, extracts and extends load data, and hands
// mem_result plus an opaque side-band (wb_pass) to WB. A WB flush (cancel)
// kills the held instruction. A bus transaction that the slave has already
// been asked for is still finished on the bus: a request is never withdrawn,
// and the data beat of a killed access is swallowed.
//
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   EXE_over            EXE offers a finished instruction
//   MEM_allow_in        MEM can take that instruction this cycle
//   ex_mem_op[3:0]      {is_load, is_store, sign_ext, reserved}
//   ex_size[1:0]        0 = byte, 1 = half, 2 = word
//   ex_addr/ex_wdata    effective address / right-aligned store data
//   ex_result           ALU result, used when the op is not a load
//   ex_exc              instruction already faulted, so it never touches the bus
//   ex_pass             side-band forwarded untouched to wb_pass
//   MEM_valid/MEM_over  stage holds a live instruction / it may move to WB
//   WB_allow_in         WB can accept
//   cancel              WB exception/eret flush
//   data_*              SRAM-like data bus (req/wr/size/addr/wdata, addr_ok, data_ok, rdata)
//   mem_result          extended load value, or ex_result
//   wb_pass             registered side-band
//   MEM_wdest_vld       live instruction that writes the register file
//                       (its write enable sits in ex_pass[WEN_BIT])
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int PASS_W  = 128,
    parameter int WEN_BIT = PASS_W - 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              EXE_over,
    output logic              MEM_allow_in,
    input  logic [3:0]        ex_mem_op,
    input  logic [1:0]        ex_size,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [31:0]       ex_result,
    input  logic              ex_exc,
    input  logic [PASS_W-1:0] ex_pass,
    output logic              MEM_valid,
    output logic              MEM_over,
    input  logic              WB_allow_in,
    input  logic              cancel,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [31:0]       mem_result,
    output logic [PASS_W-1:0] wb_pass,
    output logic              MEM_wdest_vld
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Natural alignment: halves need addr[0]==0, words need addr[1:0]==0.
    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] low);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~low[0];
            default: ok = (low == 2'b00);
        endcase
        return ok;
    endfunction

    // Store data is copied onto every byte lane so the slave can pick the
    // lane it needs from the address alone.
    function automatic logic [31:0] lane_replicate(input logic [31:0] wdata, input logic [1:0] size);
        logic [31:0] rep;
        case (size)
            2'd0:    rep = {4{wdata[7:0]}};
            2'd1:    rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sext);
        logic [31:0] sh;
        logic [31:0] res;
        case (size)
            2'd0: begin
                sh  = rdata >> {off, 3'b000};
                res = {{24{sext & sh[7]}}, sh[7:0]};
            end
            2'd1: begin
                sh  = rdata >> {off[1], 4'b0000};
                res = {{16{sext & sh[15]}}, sh[15:0]};
            end
            default: begin
                sh  = rdata;
                res = sh;
            end
        endcase
        return res;
    endfunction

    state_e              state_q;
    logic                valid_q;
    logic                cancel_seen_q;   // a flush hit while the request was still waiting for addr_ok
    logic                is_load_q;
    logic                is_store_q;
    logic                sext_q;
    logic [1:0]          size_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         result_q;
    logic [PASS_W-1:0]   pass_q;

    logic                acc_s;
    logic                over_s;
    logic                orphan_s;
    logic                allow_s;
    logic                leave_s;
    logic                capture_s;
    logic [31:0]         load_val_d;
    logic                unused_op_bit_s;

    // ex_mem_op[0] carries no meaning here; the access width comes from ex_size.
    assign unused_op_bit_s = ex_mem_op[0];

    // Handshake and access decode.
    always_comb begin
        acc_s      = (ex_mem_op[3] | ex_mem_op[2]) & ~ex_exc & addr_aligned(ex_size, ex_addr[1:0]);
        over_s     = valid_q & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        // After a flush the stage is empty, but a request that is still
        // pending or a data beat still owed by the slave belongs to the
        // killed instruction; nothing new may enter until it is gone.
        orphan_s   = ~valid_q & ((state_q == ST_REQ) | (state_q == ST_DRAIN));
        allow_s    = ~orphan_s & (~valid_q | (over_s & WB_allow_in));
        leave_s    = over_s & WB_allow_in;
        // A flush also kills whatever EXE offers in the same cycle.
        capture_s  = EXE_over & allow_s & ~cancel;
        load_val_d = load_extract(data_rdata, addr_q[1:0], size_q, sext_q);
    end

    // Pipeline register, bus FSM and result capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            valid_q       <= 1'b0;
            cancel_seen_q <= 1'b0;
            is_load_q     <= 1'b0;
            is_store_q    <= 1'b0;
            sext_q        <= 1'b0;
            size_q        <= 2'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            result_q      <= 32'd0;
            pass_q        <= {PASS_W{1'b0}};
        end else begin
            if (cancel) begin
                valid_q <= 1'b0;
            end else if (capture_s) begin
                valid_q <= 1'b1;
            end else if (leave_s) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end

            if (capture_s) begin
                is_load_q  <= ex_mem_op[3];
                is_store_q <= ex_mem_op[2];
                sext_q     <= ex_mem_op[1];
                size_q     <= ex_size;
                addr_q     <= ex_addr;
                wdata_q    <= lane_replicate(ex_wdata, ex_size);
                result_q   <= ex_result;
                pass_q     <= ex_pass;
            end else begin
                pass_q     <= pass_q;
            end

            case (state_q)
                ST_IDLE: begin
                    cancel_seen_q <= 1'b0;
                    if (capture_s & acc_s) begin
                        state_q <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // The request stays up until the slave takes it, flush or not.
                    if (data_addr_ok) begin
                        cancel_seen_q <= 1'b0;
                        if (cancel | cancel_seen_q) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        cancel_seen_q <= cancel_seen_q | cancel;
                        state_q       <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    cancel_seen_q <= 1'b0;
                    if (data_data_ok) begin
                        if (cancel) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DONE;
                            if (is_load_q) begin
                                result_q <= load_val_d;
                            end else begin
                                result_q <= result_q;
                            end
                        end
                    end else if (cancel) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    cancel_seen_q <= 1'b0;
                    if (cancel) begin
                        state_q <= ST_IDLE;
                    end else if (leave_s) begin
                        if (capture_s & acc_s) begin
                            state_q <= ST_REQ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    cancel_seen_q <= 1'b0;
                    if (data_data_ok) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    cancel_seen_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    // Every output below is a plain decode of flops, except the accept
    // handshake, which must see WB_allow_in in the same cycle.
    assign MEM_allow_in  = allow_s;
    assign MEM_valid     = valid_q;
    assign MEM_over      = over_s;
    assign data_req      = (state_q == ST_REQ);
    assign data_wr       = is_store_q;
    assign data_size     = size_q;
    assign data_addr     = addr_q;
    assign data_wdata    = wdata_q;
    assign mem_result    = result_q;
    assign wb_pass       = pass_q;
    assign MEM_wdest_vld = valid_q & pass_q[WEN_BIT];

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int PASS_W = 128;

    logic              clk = 1'b0;
    logic              resetn;
    logic              EXE_over;
    logic              MEM_allow_in;
    logic [3:0]        ex_mem_op;
    logic [1:0]        ex_size;
    logic [31:0]       ex_addr;
    logic [31:0]       ex_wdata;
    logic [31:0]       ex_result;
    logic              ex_exc;
    logic [PASS_W-1:0] ex_pass;
    logic              MEM_valid;
    logic              MEM_over;
    logic              WB_allow_in;
    logic              cancel;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [31:0]       data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic [31:0]       mem_result;
    logic [PASS_W-1:0] wb_pass;
    logic              MEM_wdest_vld;

    always #5 clk = ~clk;

    mem_stage #(.PASS_W(PASS_W)) dut (
        .clk(clk), .resetn(resetn), .EXE_over(EXE_over), .MEM_allow_in(MEM_allow_in),
        .ex_mem_op(ex_mem_op), .ex_size(ex_size), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_result(ex_result), .ex_exc(ex_exc), .ex_pass(ex_pass),
        .MEM_valid(MEM_valid), .MEM_over(MEM_over), .WB_allow_in(WB_allow_in), .cancel(cancel),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .mem_result(mem_result), .wb_pass(wb_pass),
        .MEM_wdest_vld(MEM_wdest_vld)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_valid, m_acc, m_done, m_ld, m_st, m_sg;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_result;
    logic [PASS_W-1:0] m_pass;
    bit          b_req, b_dead, b_wait, b_owait;   // request pending / belongs to killed instr / data owed
    int          req_cycles;

    function automatic bit ref_aligned(input logic [1:0] sz, input logic [31:0] a);
        int unsigned gran;
        gran = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        return (a % gran) == 0;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] w, input logic [1:0] sz);
        longint unsigned wl, v;
        wl = w;
        if (sz == 2'd0)      v = (wl % 256) * 64'h01010101;
        else if (sz == 2'd1) v = (wl % 65536) * 64'h00010001;
        else                 v = wl;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sg);
        longint unsigned r, v;
        int unsigned off;
        r = rd;
        if (sz == 2'd0) begin
            off = a % 4;
            v = (r >> (8 * off)) % 256;
            if (sg && v >= 128) v = v + 64'hFFFFFF00;
        end else if (sz == 2'd1) begin
            off = (a % 4) / 2;
            v = (r >> (16 * off)) % 65536;
            if (sg && v >= 32768) v = v + 64'hFFFF0000;
        end else begin
            v = r;
        end
        return v[31:0];
    endfunction

    task automatic post_check();
        bit ov;
        ov = m_valid & (!m_acc | m_done);
        chk("valid", MEM_valid, m_valid);
        chk("over", MEM_over, ov);
        chk("data_req", data_req, b_req);
        if (b_req) begin
            req_cycles++;
            chk("data_addr", data_addr, m_addr);
            chk("data_wr", data_wr, m_st);
            chk("data_size", data_size, m_size);
            if (m_st) chk("data_wdata", data_wdata, m_wdata);
        end
        chk("wdest_vld", MEM_wdest_vld, m_valid & m_pass[PASS_W-1]);
        if (m_valid) chk("wb_pass", wb_pass, m_pass);
        if (ov) chk("mem_result", mem_result, m_result);
    endtask

    // Called at a negedge with inputs already set; advances one clock.
    task automatic tick();
        bit ov, exp_allow, leave, cap, o_req, o_dead, o_wait, o_owait;
        #1;
        ov        = m_valid & (!m_acc | m_done);
        exp_allow = !(b_req & b_dead) & !b_owait & (!m_valid | (ov & WB_allow_in));
        chk("allow_in", MEM_allow_in, exp_allow);
        leave = ov & WB_allow_in;
        if (leave) chk("wb_result", mem_result, m_result);
        cap = EXE_over & exp_allow & !cancel;
        o_req = b_req; o_dead = b_dead; o_wait = b_wait; o_owait = b_owait;
        if (o_req && data_addr_ok) begin
            b_req = 0; b_dead = 0;
            if (o_dead || cancel) b_owait = 1; else b_wait = 1;
        end
        if (o_wait && data_data_ok) begin
            b_wait = 0;
            if (!cancel) begin
                m_done = 1;
                if (m_ld) m_result = ref_load(data_rdata, m_addr, m_size, m_sg);
            end
        end
        if (o_owait && data_data_ok) b_owait = 0;
        if (cancel) begin
            m_valid = 0; m_done = 0;
            if (b_req) b_dead = 1;
            if (o_wait && !data_data_ok) begin b_wait = 0; b_owait = 1; end
        end else if (cap) begin
            m_valid = 1; m_ld = ex_mem_op[3]; m_st = ex_mem_op[2]; m_sg = ex_mem_op[1];
            m_size = ex_size; m_addr = ex_addr; m_wdata = ref_wdata(ex_wdata, ex_size);
            m_result = ex_result; m_pass = ex_pass; m_done = 0;
            m_acc = (m_ld || m_st) && !ex_exc && ref_aligned(ex_size, ex_addr);
            if (m_acc) begin b_req = 1; b_dead = 0; end
        end else if (leave) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        post_check();
    endtask

    task automatic clr();
        EXE_over = 0; cancel = 0; data_addr_ok = 0; data_data_ok = 0; WB_allow_in = 1;
    endtask

    task automatic set_instr(input bit ld, input bit st, input bit sg, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] res, input bit exc);
        EXE_over  = 1;
        ex_mem_op = {ld, st, sg, 1'($urandom_range(0, 1))};
        ex_size   = sz; ex_addr = addr; ex_wdata = wd; ex_result = res; ex_exc = exc;
        ex_pass   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Capture, addr_ok on the first request cycle, data_ok the cycle after; WB held.
    task automatic run_acc(input bit ld, input bit st, input bit sg, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] res, input logic [31:0] rd);
        clr(); set_instr(ld, st, sg, sz, addr, wd, res, 0); WB_allow_in = 0; tick();
        clr(); WB_allow_in = 0; data_addr_ok = 1; tick();
        clr(); WB_allow_in = 0; data_data_ok = 1; data_rdata = rd; tick();
    endtask

    logic [PASS_W-1:0] p6;

    initial begin
        resetn = 0; clr(); ex_mem_op = 4'd0; ex_size = 2'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
        ex_result = 32'd0; ex_exc = 0; ex_pass = '0; data_rdata = 32'd0;
        m_valid = 0; m_acc = 0; m_done = 0; m_ld = 0; m_st = 0; m_sg = 0; m_size = 2'd0;
        m_addr = 32'd0; m_wdata = 32'd0; m_result = 32'd0; m_pass = '0;
        b_req = 0; b_dead = 0; b_wait = 0; b_owait = 0; req_cycles = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", MEM_valid, 1'b0);
        chk("rst_over", MEM_over, 1'b0);
        chk("rst_req", data_req, 1'b0);
        chk("rst_result", mem_result, 32'd0);
        chk("rst_pass", wb_pass, 128'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_allow", MEM_allow_in, 1'b1);
        resetn = 1;

        // 1: lw 0x1000, request high two cycles, data three cycles later
        clr(); set_instr(1, 0, 0, 2'd2, 32'h1000, 32'd0, 32'h11111111, 0); WB_allow_in = 0;
        req_cycles = 0; tick();
        clr(); WB_allow_in = 0; tick();
        clr(); WB_allow_in = 0; data_addr_ok = 1; tick();
        chk("t1_over_wait", MEM_over, 1'b0);
        clr(); WB_allow_in = 0; tick();
        clr(); WB_allow_in = 0; data_data_ok = 1; data_rdata = 32'hDEADBEEF; tick();
        chk("t1_req_cycles", req_cycles, 2);
        chk("t1_over", MEM_over, 1'b1);
        chk("t1_result", mem_result, 32'hDEADBEEF);
        clr(); tick();

        // 2: byte/half loads with extension
        run_acc(1, 0, 1, 2'd0, 32'h1003, 32'd0, 32'd0, 32'h80FF0000);
        chk("t2_lb", mem_result, 32'hFFFFFF80);
        clr(); tick();
        run_acc(1, 0, 0, 2'd0, 32'h1003, 32'd0, 32'd0, 32'h80FF0000);
        chk("t2_lbu", mem_result, 32'h00000080);
        clr(); tick();
        run_acc(1, 0, 1, 2'd1, 32'h1002, 32'd0, 32'd0, 32'h80FF0000);
        chk("t2_lh", mem_result, 32'hFFFF80FF);
        clr(); tick();

        // 3: sb lane replication; completion only after data_ok
        clr(); set_instr(0, 1, 0, 2'd0, 32'h2001, 32'h12345678, 32'h0000ABCD, 0); WB_allow_in = 0; tick();
        chk("t3_wdata", data_wdata, 32'h78787878);
        chk("t3_size", data_size, 2'd0);
        chk("t3_wr", data_wr, 1'b1);
        clr(); WB_allow_in = 0; data_addr_ok = 1; tick();
        chk("t3_over_before_ok", MEM_over, 1'b0);
        clr(); WB_allow_in = 0; tick();
        chk("t3_over_still", MEM_over, 1'b0);
        clr(); WB_allow_in = 0; data_data_ok = 1; tick();
        chk("t3_over", MEM_over, 1'b1);
        chk("t3_result", mem_result, 32'h0000ABCD);
        clr(); tick();

        // 4: cancel while the request waits for addr_ok
        clr(); set_instr(1, 0, 0, 2'd2, 32'h4000, 32'd0, 32'd0, 0); tick();
        clr(); cancel = 1; tick();
        chk("t4_req_held", data_req, 1'b1);
        chk("t4_valid", MEM_valid, 1'b0);
        clr(); #1 chk("t4_allow_req", MEM_allow_in, 1'b0);
        data_addr_ok = 1; tick();
        chk("t4_req_drop", data_req, 1'b0);
        clr(); set_instr(1, 0, 0, 2'd2, 32'h4100, 32'd0, 32'd0, 0);
        #1 chk("t4_allow_drain", MEM_allow_in, 1'b0);
        tick();
        chk("t4_no_capture", MEM_valid, 1'b0);
        clr(); data_data_ok = 1; data_rdata = 32'h5555AAAA; tick();
        chk("t4_swallowed", MEM_over, 1'b0);
        clr(); #1 chk("t4_allow_idle", MEM_allow_in, 1'b1);

        // 5: misaligned access and pre-faulted access never reach the bus
        clr(); set_instr(1, 0, 0, 2'd2, 32'h1002, 32'd0, 32'hCAFEF00D, 0); WB_allow_in = 0; tick();
        chk("t5_mis_req", data_req, 1'b0);
        chk("t5_mis_over", MEM_over, 1'b1);
        chk("t5_mis_result", mem_result, 32'hCAFEF00D);
        clr(); tick();
        clr(); set_instr(0, 1, 0, 2'd2, 32'h1004, 32'h1, 32'h00C0FFEE, 1); WB_allow_in = 0; tick();
        chk("t5_exc_req", data_req, 1'b0);
        chk("t5_exc_result", mem_result, 32'h00C0FFEE);
        clr(); tick();

        // 6: WB stall in DONE, then back-to-back capture on release
        run_acc(1, 0, 0, 2'd2, 32'h1000, 32'd0, 32'd0, 32'h0BADF00D);
        p6 = ex_pass;
        for (int k = 0; k < 3; k++) begin
            clr(); WB_allow_in = 0; tick();
            chk("t6_hold_result", mem_result, 32'h0BADF00D);
            chk("t6_hold_pass", wb_pass, p6);
            chk("t6_hold_noreq", data_req, 1'b0);
        end
        clr(); set_instr(1, 0, 0, 2'd2, 32'h3000, 32'd0, 32'd0, 0); tick();
        chk("t6_next_req", data_req, 1'b1);
        chk("t6_next_addr", data_addr, 32'h3000);
        clr(); data_addr_ok = 1; tick();
        clr(); data_data_ok = 1; data_rdata = $urandom(); tick();
        clr(); tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int kind;
            logic [1:0]  sz;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 2));
            a    = $urandom();
            if ($urandom_range(0, 3) != 0) a = a - (a % (32'd1 << sz));
            set_instr(kind == 1, kind == 2, $urandom_range(0, 1) == 1, sz, a, $urandom(), $urandom(),
                      $urandom_range(0, 7) == 0);
            cancel       = ($urandom_range(0, 24) == 0);
            EXE_over     = !cancel && ($urandom_range(0, 2) != 0);
            WB_allow_in  = ($urandom_range(0, 3) != 0);
            data_addr_ok = data_req && ($urandom_range(0, 1) == 1);
            data_data_ok = (b_wait || b_owait) && ($urandom_range(0, 2) == 0);
            data_rdata   = $urandom();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
